// File: rtl/neocore_pkg.sv
// neocore_pkg: shared types and constants for the neocore pipeline.
// The writeback queue pulls its default depth, write-port count and entry
// layout from here so that decode and writeback agree on them.
package neocore_pkg;

  // Default writeback queue geometry.
  localparam int WBQ_DEPTH_DEFAULT  = 4;
  localparam int NUM_WB_PORTS       = 2;
  localparam int WBQ_ADDR_W_DEFAULT = 4;
  localparam int WBQ_DATA_W_DEFAULT = 16;

  // One queued writeback: destination register and result value.
  typedef struct packed {
    logic [WBQ_ADDR_W_DEFAULT-1:0] rd;
    logic [WBQ_DATA_W_DEFAULT-1:0] data;
  } wbq_entry_t;

  // Number of set bits in a two-bit enable vector, 0..2.
  function automatic logic [1:0] wbq_pop2(input logic [1:0] en);
    return {en[1] & en[0], en[1] ^ en[0]};
  endfunction

endpackage

// File: rtl/wbq_pending_tracker.sv
// wbq_pending_tracker: builds the per-register pending mask used by decode
// for hazard detection. A bit is set while any valid queue entry targets
// that register. Inputs come straight from the queue's state flops, so the
// mask changes only at clock edges.
module wbq_pending_tracker #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic [DEPTH-1:0]        entry_valid,
  input  logic [DEPTH*ADDR_W-1:0] entry_rd_flat,
  output logic [2**ADDR_W-1:0]    pending_mask
);

  // OR together one-hot(rd) of every valid entry.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_mask[entry_rd_flat[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: ordered result buffer between the two execution lanes and
// the register file write ports. Up to two results enter per cycle (lane 0
// older than lane 1) and up to two retire per cycle, oldest on port 0.
// When both ports target the same register, port 1 carries the younger value
// and the register file lets port 1 win.
//
// Optional feature: define WRITEBACK_QUEUE_BYPASS_EN to let accepted results
// go straight to the write ports in the same cycle while the queue is empty
// and not stalled. Without it there is no input-to-output combinational path.
module writeback_queue
  import neocore_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH_DEFAULT,
  parameter int DATA_W = WBQ_DATA_W_DEFAULT,
  parameter int ADDR_W = WBQ_ADDR_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       res_valid_0,
  input  logic [ADDR_W-1:0]          res_rd_0,
  input  logic [DATA_W-1:0]          res_data_0,
  output logic                       res_ready_0,

  input  logic                       res_valid_1,
  input  logic [ADDR_W-1:0]          res_rd_1,
  input  logic [DATA_W-1:0]          res_data_1,
  output logic                       res_ready_1,

  input  logic                       wb_stall,

  output logic                       rd_we_0,
  output logic [ADDR_W-1:0]          rd_addr_0,
  output logic [DATA_W-1:0]          rd_data_0,

  output logic                       rd_we_1,
  output logic [ADDR_W-1:0]          rd_addr_1,
  output logic [DATA_W-1:0]          rd_data_1,

  output logic [2**ADDR_W-1:0]       pending_mask,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Highest occupancy at which each lane can still be accepted.
  localparam logic [CW-1:0] READY0_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] READY1_MAX = CW'(DEPTH - 2);

  // Queue state.
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] entry_rd_q   [DEPTH];
  logic [DATA_W-1:0] entry_data_q [DEPTH];

  // Handshake, enqueue and retire controls.
  logic                    fire_0;
  logic                    fire_1;
  logic [NUM_WB_PORTS-1:0] enq;
  logic [NUM_WB_PORTS-1:0] ret;
  logic [1:0]              num_acc;
  logic [1:0]              num_ret;
  logic [PW-1:0]           head_p1;
  logic [PW-1:0]           lane1_idx;
  logic [DEPTH*ADDR_W-1:0] entry_rd_flat;

  // Readiness looks only at the registered occupancy, so a lane is never
  // refused or accepted based on what retires in the same cycle.
  assign res_ready_0 = (count_q <= READY0_MAX);
  assign res_ready_1 = (count_q <= READY1_MAX);

  assign fire_0 = res_valid_0 && res_ready_0;
  assign fire_1 = res_valid_1 && res_ready_1;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  // An empty, unstalled queue forwards accepted results instead of storing them.
  logic bypass;
  assign bypass = (count_q == '0) && !wb_stall;
  assign enq    = {fire_1 && !bypass, fire_0 && !bypass};
`else
  assign enq    = {fire_1, fire_0};
`endif

  // The two oldest entries retire unless the register file is holding.
  assign ret[0] = (count_q >= CW'(1)) && !wb_stall;
  assign ret[1] = (count_q >= CW'(2)) && !wb_stall;

  assign num_acc = wbq_pop2(enq);
  assign num_ret = wbq_pop2(ret);

  // Pointer arithmetic wraps naturally at DEPTH because PW = log2(DEPTH).
  assign head_p1   = head_q + PW'(1);
  assign lane1_idx = enq[0] ? (tail_q + PW'(1)) : tail_q;

  assign count = count_q;

  // Drive the register file write ports from the head entries, zeroing
  // address and data whenever a port is idle.
  always_comb begin
    rd_we_0   = ret[0];
    rd_addr_0 = ret[0] ? entry_rd_q[head_q]    : '0;
    rd_data_0 = ret[0] ? entry_data_q[head_q]  : '0;
    rd_we_1   = ret[1];
    rd_addr_1 = ret[1] ? entry_rd_q[head_p1]   : '0;
    rd_data_1 = ret[1] ? entry_data_q[head_p1] : '0;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    if (bypass) begin
      rd_we_0   = fire_0 || fire_1;
      rd_addr_0 = fire_0 ? res_rd_0   : (fire_1 ? res_rd_1   : '0);
      rd_data_0 = fire_0 ? res_data_0 : (fire_1 ? res_data_1 : '0);
      rd_we_1   = fire_0 && fire_1;
      rd_addr_1 = (fire_0 && fire_1) ? res_rd_1   : '0;
      rd_data_1 = (fire_0 && fire_1) ? res_data_1 : '0;
    end
`endif
  end

  // Advance pointers and occupancy, retire head entries and store accepted
  // results in program order. Enqueue slots never overlap live entries
  // because acceptance is bounded by the free space, so clears and sets
  // never collide on the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_rd_q[i]   <= '0;
        entry_data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_q + PW'(num_ret);
      tail_q  <= tail_q + PW'(num_acc);
      count_q <= count_q + CW'(num_acc) - CW'(num_ret);

      if (ret[0]) begin
        valid_q[head_q] <= 1'b0;
      end
      if (ret[1]) begin
        valid_q[head_p1] <= 1'b0;
      end

      if (enq[0]) begin
        valid_q[tail_q]      <= 1'b1;
        entry_rd_q[tail_q]   <= res_rd_0;
        entry_data_q[tail_q] <= res_data_0;
      end
      if (enq[1]) begin
        valid_q[lane1_idx]      <= 1'b1;
        entry_rd_q[lane1_idx]   <= res_rd_1;
        entry_data_q[lane1_idx] <= res_data_1;
      end
    end
  end

  // Flatten the destination fields for the pending tracker.
  always_comb begin
    entry_rd_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd_flat[i*ADDR_W +: ADDR_W] = entry_rd_q[i];
    end
  end

  wbq_pending_tracker #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_pending_tracker (
    .entry_valid   (valid_q),
    .entry_rd_flat (entry_rd_flat),
    .pending_mask  (pending_mask)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed bench for writeback_queue. A small register
// file model absorbs the write ports (port 1 applied after port 0) so that
// final register contents can be compared with hand-computed values.
// Builds with or without WRITEBACK_QUEUE_BYPASS_EN.
module tb_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              res_valid_0, res_valid_1;
  logic [ADDR_W-1:0] res_rd_0, res_rd_1;
  logic [DATA_W-1:0] res_data_0, res_data_1;
  logic              res_ready_0, res_ready_1;
  logic              wb_stall;
  logic              rd_we_0, rd_we_1;
  logic [ADDR_W-1:0] rd_addr_0, rd_addr_1;
  logic [DATA_W-1:0] rd_data_0, rd_data_1;
  logic [15:0]       pending_mask;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] reg_file [16] = '{default: '0};
  bit                logging = 1'b0;
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];

  always #5 clk = ~clk;

  writeback_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_valid_0  (res_valid_0),
    .res_rd_0     (res_rd_0),
    .res_data_0   (res_data_0),
    .res_ready_0  (res_ready_0),
    .res_valid_1  (res_valid_1),
    .res_rd_1     (res_rd_1),
    .res_data_1   (res_data_1),
    .res_ready_1  (res_ready_1),
    .wb_stall     (wb_stall),
    .rd_we_0      (rd_we_0),
    .rd_addr_0    (rd_addr_0),
    .rd_data_0    (rd_data_0),
    .rd_we_1      (rd_we_1),
    .rd_addr_1    (rd_addr_1),
    .rd_data_1    (rd_data_1),
    .pending_mask (pending_mask),
    .count        (count)
  );

  // Register file model plus an in-order log of writes for the wrap test.
  always @(posedge clk) begin
    if (rd_we_0) reg_file[rd_addr_0] <= rd_data_0;
    if (rd_we_1) reg_file[rd_addr_1] <= rd_data_1;
    if (logging) begin
      if (rd_we_0) begin log_addr.push_back(rd_addr_0); log_data.push_back(rd_data_0); end
      if (rd_we_1) begin log_addr.push_back(rd_addr_1); log_data.push_back(rd_data_1); end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Occupancy must never exceed the queue depth.
  always @(negedge clk) begin
    if (rst_n === 1'b1) checkOutput("count_bound", 32'(count <= 3'd4), 32'd1);
  end

  task automatic applyStimulus(input logic v0, input logic [3:0] rd0, input logic [15:0] d0,
                               input logic v1, input logic [3:0] rd1, input logic [15:0] d1,
                               input logic stall);
    res_valid_0 = v0; res_rd_0 = rd0; res_data_0 = d0;
    res_valid_1 = v1; res_rd_1 = rd1; res_data_1 = d1;
    wb_stall    = stall;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ready0", 32'(res_ready_0), 32'd1);
    checkOutput("rst_ready1", 32'(res_ready_1), 32'd1);
    checkOutput("rst_we0", 32'(rd_we_0), 32'd0);
    checkOutput("rst_we1", 32'(rd_we_1), 32'd0);
    checkOutput("rst_mask", 32'(pending_mask), 32'd0);
    checkOutput("rst_addr0", 32'(rd_addr_0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single result R1 = 0x1234 on lane 0.
    applyStimulus(1, 4'd1, 16'h1234, 0, 0, 0, 0);
    #1;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    checkOutput("t1_we0_bypass", 32'(rd_we_0), 32'd1);
    checkOutput("t1_data0_bypass", 32'(rd_data_0), 32'h1234);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
`else
    checkOutput("t1_we0_early", 32'(rd_we_0), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t1_we0", 32'(rd_we_0), 32'd1);
    checkOutput("t1_addr0", 32'(rd_addr_0), 32'd1);
    checkOutput("t1_data0", 32'(rd_data_0), 32'h1234);
    checkOutput("t1_we1", 32'(rd_we_1), 32'd0);
    checkOutput("t1_mask1", 32'(pending_mask[1]), 32'd1);
    checkOutput("t1_count1", 32'(count), 32'd1);
    step();
`endif
    checkOutput("t1_count0", 32'(count), 32'd0);
    checkOutput("t1_mask0", 32'(pending_mask), 32'd0);
    checkOutput("t1_r1", 32'(reg_file[1]), 32'h1234);

    // Same-register pair R5: lane 0 0xBEEF, lane 1 0xCAFE.
    applyStimulus(1, 4'd5, 16'hBEEF, 1, 4'd5, 16'hCAFE, 0);
`ifndef WRITEBACK_QUEUE_BYPASS_EN
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t2_count2", 32'(count), 32'd2);
    checkOutput("t2_mask", 32'(pending_mask), 32'h0020);
`else
    #1;
`endif
    checkOutput("t2_we0", 32'(rd_we_0), 32'd1);
    checkOutput("t2_addr0", 32'(rd_addr_0), 32'd5);
    checkOutput("t2_data0", 32'(rd_data_0), 32'hBEEF);
    checkOutput("t2_we1", 32'(rd_we_1), 32'd1);
    checkOutput("t2_addr1", 32'(rd_addr_1), 32'd5);
    checkOutput("t2_data1", 32'(rd_data_1), 32'hCAFE);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_r5", 32'(reg_file[5]), 32'hCAFE);
    checkOutput("t2_count0", 32'(count), 32'd0);

    // Fill under stall with R2..R5, then release.
    applyStimulus(1, 4'd2, 16'h0202, 1, 4'd3, 16'h0303, 1);
    #1;
    checkOutput("t3_ready1_empty", 32'(res_ready_1), 32'd1);
    step();
    applyStimulus(1, 4'd4, 16'h0404, 1, 4'd5, 16'h0505, 1);
    #1;
    checkOutput("t3_count2", 32'(count), 32'd2);
    checkOutput("t3_we0_stall", 32'(rd_we_0), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("t3_count4", 32'(count), 32'd4);
    checkOutput("t3_ready0_full", 32'(res_ready_0), 32'd0);
    checkOutput("t3_ready1_full", 32'(res_ready_1), 32'd0);
    checkOutput("t3_we0_full", 32'(rd_we_0), 32'd0);
    checkOutput("t3_we1_full", 32'(rd_we_1), 32'd0);
    checkOutput("t3_mask", 32'(pending_mask), 32'h003C);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t3_addr0_a", 32'(rd_addr_0), 32'd2);
    checkOutput("t3_data0_a", 32'(rd_data_0), 32'h0202);
    checkOutput("t3_addr1_a", 32'(rd_addr_1), 32'd3);
    checkOutput("t3_data1_a", 32'(rd_data_1), 32'h0303);
    step();
    checkOutput("t3_addr0_b", 32'(rd_addr_0), 32'd4);
    checkOutput("t3_data0_b", 32'(rd_data_0), 32'h0404);
    checkOutput("t3_addr1_b", 32'(rd_addr_1), 32'd5);
    checkOutput("t3_data1_b", 32'(rd_data_1), 32'h0505);
    step();
    checkOutput("t3_count0", 32'(count), 32'd0);
    checkOutput("t3_r2", 32'(reg_file[2]), 32'h0202);
    checkOutput("t3_r5", 32'(reg_file[5]), 32'h0505);

    // Wrap-around: R1..R10 = 0x0100+i with every third cycle stalled.
    logging = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 4'(i), 16'(16'h0100 + i), 0, 0, 0, (i % 3) == 0);
      n = 0;
      while (!res_ready_0 && n < 8) begin
        step();
        n++;
      end
      checkOutput("wrap_ready", 32'(res_ready_0), 32'd1);
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (count != 3'd0 && n < 16) begin
      step();
      n++;
    end
    logging = 1'b0;
    checkOutput("wrap_drain", 32'(count), 32'd0);
    checkOutput("wrap_len", 32'(log_addr.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      checkOutput("wrap_addr", (k < log_addr.size()) ? 32'(log_addr[k]) : 32'hFFFF_FFFF, 32'(k + 1));
      checkOutput("wrap_data", (k < log_data.size()) ? 32'(log_data[k]) : 32'hFFFF_FFFF, 32'(16'h0101 + k));
    end

    // Reset with three queued entries, one of them a write to R7.
    applyStimulus(1, 4'd6, 16'hAA06, 1, 4'd7, 16'hAA07, 1);
    step();
    applyStimulus(1, 4'd8, 16'hAA08, 0, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("t5_count3", 32'(count), 32'd3);
    wb_stall = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("t5_count_rst", 32'(count), 32'd0);
    checkOutput("t5_we0_rst", 32'(rd_we_0), 32'd0);
    checkOutput("t5_we1_rst", 32'(rd_we_1), 32'd0);
    checkOutput("t5_addr0_rst", 32'(rd_addr_0), 32'd0);
    checkOutput("t5_data0_rst", 32'(rd_data_0), 32'd0);
    checkOutput("t5_mask_rst", 32'(pending_mask), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    checkOutput("t5_r6", 32'(reg_file[6]), 32'h0106);
    checkOutput("t5_r7", 32'(reg_file[7]), 32'h0107);
    checkOutput("t5_r8", 32'(reg_file[8]), 32'h0108);
    checkOutput("t5_count_after", 32'(count), 32'd0);

    // Empty queue, R4 = 0xDEAD: zero latency with bypass, one cycle without.
    applyStimulus(1, 4'd4, 16'hDEAD, 0, 0, 0, 0);
    #1;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    checkOutput("t6_we0_bypass", 32'(rd_we_0), 32'd1);
    checkOutput("t6_addr0_bypass", 32'(rd_addr_0), 32'd4);
    checkOutput("t6_data0_bypass", 32'(rd_data_0), 32'hDEAD);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_count_bypass", 32'(count), 32'd0);
`else
    checkOutput("t6_we0_early", 32'(rd_we_0), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t6_we0", 32'(rd_we_0), 32'd1);
    checkOutput("t6_data0", 32'(rd_data_0), 32'hDEAD);
    step();
`endif
    checkOutput("t6_r4", 32'(reg_file[4]), 32'hDEAD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
